// File: rtl/decode.sv
// RV32I integer-subset decoder/executor: a 32-entry register file plus a
// single-cycle ALU. Each rising edge executes the instruction on opcode and
// registers its ALU output on result and into rd.
module decode #(
  parameter int unsigned N = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   opcode,
  output logic [N-1:0]  result
);

  localparam int unsigned ShW = $clog2(N);

  localparam logic [6:0] OpReg = 7'b0110011;
  localparam logic [6:0] OpImm = 7'b0010011;
  localparam logic [6:0] OpLui = 7'b0110111;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;

  typedef enum logic [3:0] {
    AluAdd,
    AluSub,
    AluSll,
    AluSlt,
    AluSltu,
    AluXor,
    AluSrl,
    AluSra,
    AluOr,
    AluAnd,
    AluLui
  } alu_op_e;

  // Instruction fields
  logic [6:0] funct7;
  logic [4:0] rs2_idx;
  logic [4:0] rs1_idx;
  logic [2:0] funct3;
  logic [4:0] rd_idx;
  logic [6:0] major;

  assign funct7  = opcode[31:25];
  assign rs2_idx = opcode[24:20];
  assign rs1_idx = opcode[19:15];
  assign funct3  = opcode[14:12];
  assign rd_idx  = opcode[11:7];
  assign major   = opcode[6:0];

  // State
  logic [N-1:0] regs_q [32];
  logic [N-1:0] result_q, result_d;
  logic         wr_en;

  // Immediates, built bit by bit so any width from 8 to 64 works without
  // out-of-range selects: I-imm sign-extends bit 31, LUI sign-extends or
  // truncates the 32-bit upper-immediate value.
  logic [N-1:0] imm_i;
  logic [N-1:0] imm_u;

  for (genvar i = 0; i < N; i++) begin : g_imm
    if (i < 12) begin : g_lo
      assign imm_i[i] = opcode[20+i];
      assign imm_u[i] = 1'b0;
    end else if (i < 32) begin : g_mid
      assign imm_i[i] = opcode[31];
      assign imm_u[i] = opcode[i];
    end else begin : g_hi
      assign imm_i[i] = opcode[31];
      assign imm_u[i] = opcode[31];
    end
  end

  // Combinational register reads; x0 is hard-wired to zero
  logic [N-1:0] rs1_val;
  logic [N-1:0] rs2_val;

  assign rs1_val = (rs1_idx == 5'd0) ? '0 : regs_q[rs1_idx];
  assign rs2_val = (rs2_idx == 5'd0) ? '0 : regs_q[rs2_idx];

  // I-type shifts carry funct7 in imm[11:5]; at N=64 bit 25 is part of the
  // 6-bit shift amount and must not count against legality.
  logic shift_imm_base;
  logic shift_imm_alt;

  if (N > 32) begin : g_f7_wide
    assign shift_imm_base = (funct7[6:1] == F7Base[6:1]);
    assign shift_imm_alt  = (funct7[6:1] == F7Alt[6:1]);
  end else begin : g_f7_narrow
    assign shift_imm_base = (funct7 == F7Base);
    assign shift_imm_alt  = (funct7 == F7Alt);
  end

  // Decode: legality, ALU operation and operand-B source
  alu_op_e alu_op;
  logic    legal;
  logic    use_imm;

  always_comb begin
    legal   = 1'b0;
    alu_op  = AluAdd;
    use_imm = 1'b0;
    unique case (major)
      OpReg: begin
        unique case (funct3)
          3'b000: begin
            legal  = (funct7 == F7Base) || (funct7 == F7Alt);
            alu_op = (funct7 == F7Alt) ? AluSub : AluAdd;
          end
          3'b001: begin
            legal  = (funct7 == F7Base);
            alu_op = AluSll;
          end
          3'b010: begin
            legal  = (funct7 == F7Base);
            alu_op = AluSlt;
          end
          3'b011: begin
            legal  = (funct7 == F7Base);
            alu_op = AluSltu;
          end
          3'b100: begin
            legal  = (funct7 == F7Base);
            alu_op = AluXor;
          end
          3'b101: begin
            legal  = (funct7 == F7Base) || (funct7 == F7Alt);
            alu_op = (funct7 == F7Alt) ? AluSra : AluSrl;
          end
          3'b110: begin
            legal  = (funct7 == F7Base);
            alu_op = AluOr;
          end
          default: begin
            legal  = (funct7 == F7Base);
            alu_op = AluAnd;
          end
        endcase
      end
      OpImm: begin
        use_imm = 1'b1;
        legal   = 1'b1;
        unique case (funct3)
          3'b000:  alu_op = AluAdd;
          3'b001: begin
            legal  = shift_imm_base;
            alu_op = AluSll;
          end
          3'b010:  alu_op = AluSlt;
          3'b011:  alu_op = AluSltu;
          3'b100:  alu_op = AluXor;
          3'b101: begin
            legal  = shift_imm_base || shift_imm_alt;
            alu_op = shift_imm_alt ? AluSra : AluSrl;
          end
          3'b110:  alu_op = AluOr;
          default: alu_op = AluAnd;
        endcase
      end
      OpLui: begin
        legal  = 1'b1;
        alu_op = AluLui;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // ALU
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic [ShW-1:0] shamt;
  logic [N-1:0]   alu_out;

  assign op_a  = rs1_val;
  assign op_b  = use_imm ? imm_i : rs2_val;
  assign shamt = op_b[ShW-1:0];

  always_comb begin
    alu_out = '0;
    unique case (alu_op)
      AluAdd:  alu_out = op_a + op_b;
      AluSub:  alu_out = op_a - op_b;
      AluSll:  alu_out = op_a << shamt;
      AluSlt:  alu_out = {{(N-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      AluSltu: alu_out = {{(N-1){1'b0}}, (op_a < op_b)};
      AluXor:  alu_out = op_a ^ op_b;
      AluSrl:  alu_out = op_a >> shamt;
      AluSra:  alu_out = $unsigned($signed(op_a) >>> shamt);
      AluOr:   alu_out = op_a | op_b;
      AluAnd:  alu_out = op_a & op_b;
      AluLui:  alu_out = imm_u;
      default: alu_out = '0;
    endcase
  end

  // Next state: illegal instructions hold result and write nothing
  always_comb begin
    result_d = legal ? alu_out : result_q;
    wr_en    = legal && (rd_idx != 5'd0);
  end

  // Result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  // Register file; entry 0 is never written and never read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[rd_idx] <= alu_out;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode (N=32): hand-computed results for an RV32I
// instruction stream, with register contents observed through later
// instructions that copy them onto result.
module tb_decode;

  logic        clk;
  logic        rst;
  logic [31:0] opcode;
  logic [31:0] result;

  int unsigned n_cmp;
  int unsigned n_err;

  decode #(
    .N(32)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .opcode(opcode),
    .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] lui(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive an instruction between edges, let one edge execute it, sample after
  task automatic step(input logic [31:0] instr);
    @(negedge clk);
    opcode = instr;
    @(posedge clk);
    #1;
  endtask

  task automatic step_check(input string tag, input logic [31:0] instr,
                            input logic [31:0] exp);
    step(instr);
    check_eq(tag, result, exp);
  endtask

  localparam logic [6:0] B = 7'b0000000;
  localparam logic [6:0] A = 7'b0100000;

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b1;
    // addi x1,x0,9 sits on the bus while reset is high; it must not execute
    opcode = i_type(12'd9, 5'd0, 3'b000, 5'd1);
    #2;
    check_eq("reset_immediate", result, 32'h0);
    @(posedge clk);
    #1;
    check_eq("reset_held_edge", result, 32'h0);
    @(negedge clk);
    rst    = 1'b0;
    opcode = r_type(B, 5'd0, 5'd1, 3'b000, 5'd0);
    @(posedge clk);
    #1;
    check_eq("add_x0_edge1", result, 32'h0);
    step_check("add_x0_edge2", r_type(B, 5'd0, 5'd1, 3'b000, 5'd0), 32'h0);
    step_check("x1_not_written_in_reset", r_type(B, 5'd0, 5'd1, 3'b000, 5'd11), 32'h0);

    // Basic arithmetic with back-to-back dependencies
    step_check("addi_x1_5",  i_type(12'd5, 5'd0, 3'b000, 5'd1), 32'h5);
    step_check("addi_x2_m3", i_type(12'hFFD, 5'd0, 3'b000, 5'd2), 32'hFFFF_FFFD);
    step_check("add_x3",     r_type(B, 5'd2, 5'd1, 3'b000, 5'd3), 32'h2);

    step_check("sub_x4",  r_type(A, 5'd2, 5'd1, 3'b000, 5'd4), 32'h8);
    step_check("slt_x5",  r_type(B, 5'd1, 5'd2, 3'b010, 5'd5), 32'h1);
    step_check("sltu_x6", r_type(B, 5'd1, 5'd2, 3'b011, 5'd6), 32'h0);

    step_check("srai_x7", i_type(12'h401, 5'd2, 3'b101, 5'd7), 32'hFFFF_FFFE);
    step_check("srli_x8", i_type(12'h01C, 5'd2, 3'b101, 5'd8), 32'h0000_000F);
    step_check("slli_x9", i_type(12'h01F, 5'd1, 3'b001, 5'd9), 32'h8000_0000);

    // Remaining ALU operations
    step_check("xori_x15",  i_type(12'hFFF, 5'd1, 3'b100, 5'd15), 32'hFFFF_FFFA);
    step_check("or_x16",    r_type(B, 5'd2, 5'd1, 3'b110, 5'd16), 32'hFFFF_FFFD);
    step_check("and_x17",   r_type(B, 5'd2, 5'd1, 3'b111, 5'd17), 32'h5);
    step_check("sltiu_x18", i_type(12'hFFF, 5'd1, 3'b011, 5'd18), 32'h1);
    step_check("slti_x19",  i_type(12'hFFF, 5'd1, 3'b010, 5'd19), 32'h0);
    step_check("sra_x20",   r_type(A, 5'd1, 5'd2, 3'b101, 5'd20), 32'hFFFF_FFFF);
    step_check("srl_x21",   r_type(B, 5'd1, 5'd2, 3'b101, 5'd21), 32'h07FF_FFFF);
    step_check("sll_x22",   r_type(B, 5'd1, 5'd1, 3'b001, 5'd22), 32'h0000_00A0);
    step_check("lui_x14",   lui(20'h12345, 5'd14), 32'h1234_5000);
    step_check("read_x14",  r_type(B, 5'd0, 5'd14, 3'b000, 5'd23), 32'h1234_5000);

    // Illegal instructions hold result and write nothing
    step_check("add_x3_again", r_type(B, 5'd2, 5'd1, 3'b000, 5'd3), 32'h2);
    step_check("illegal_major", 32'hFFFF_FFFF, 32'h2);
    step_check("illegal_f7_add", r_type(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd24), 32'h2);
    step_check("illegal_f7_sll", r_type(A, 5'd2, 5'd1, 3'b001, 5'd25), 32'h2);
    step_check("illegal_slli_f7", i_type(12'h401, 5'd1, 3'b001, 5'd26), 32'h2);
    step_check("x31_unwritten", r_type(B, 5'd0, 5'd31, 3'b000, 5'd12), 32'h0);
    step_check("x24_unwritten", r_type(B, 5'd0, 5'd24, 3'b000, 5'd12), 32'h0);
    step_check("x1_intact",     r_type(B, 5'd0, 5'd1, 3'b000, 5'd12), 32'h5);

    // rd=0: result updates, register write suppressed
    step_check("addi_x0_7",  i_type(12'd7, 5'd0, 3'b000, 5'd0), 32'h7);
    step_check("x0_reads_0", r_type(B, 5'd0, 5'd0, 3'b000, 5'd13), 32'h0);

    // Asynchronous reset pulse between edges clears everything
    step_check("pre_reset_x3", r_type(B, 5'd0, 5'd3, 3'b000, 5'd13), 32'h2);
    @(negedge clk);
    opcode = r_type(B, 5'd3, 5'd1, 3'b000, 5'd10);
    #1;
    rst = 1'b1;
    #1;
    check_eq("reset_pulse_immediate", result, 32'h0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("add_x10_after_reset", result, 32'h0);
    step_check("x2_cleared", r_type(B, 5'd0, 5'd2, 3'b000, 5'd11), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning the data-path and register width in bits (power of two, 8..64).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port opcode  input  32  RV32I instruction word, sampled at each rising clk edge.
REQ-005 The block SHALL have port result  output  N  registered ALU result of the last legal instruction.

Function
REQ-006 The block SHALL contain 32 registers x0..x31, each N bits wide; x0 SHALL always read 0 and SHALL ignore writes.
REQ-007 Instruction fields SHALL be: funct7[31:25], rs2[24:20], rs1[19:15], funct3[14:12], rd[11:7], major opcode[6:0].
REQ-008 Register reads of rs1 and rs2 SHALL be combinational from current register contents.
REQ-009 Major opcode 0110011 (R-type) SHALL execute ADD/SUB (funct3 000, funct7 0000000/0100000), SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101 (funct7 0000000/0100000), OR 110, AND 111.
REQ-010 Major opcode 0010011 (I-type) SHALL execute ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI and SRAI with the same funct3 encoding as REQ-009.
REQ-011 The I-type immediate SHALL be opcode[31:20], sign-extended to N bits; SLTIU SHALL compare against the sign-extended immediate as unsigned.
REQ-012 Major opcode 0110111 (LUI) SHALL produce {opcode[31:12], 12'b0}, sign-extended or truncated to N bits.
REQ-013 Shift amount SHALL be the low log2(N) bits of rs2 value (R-type) or of imm (I-type); SRA/SRAI SHALL replicate bit N-1.
REQ-014 SLT/SLTI SHALL compare signed and SLTU/SLTIU unsigned, producing 1 or 0 zero-extended to N bits.
REQ-015 Arithmetic SHALL be modulo 2^N; overflow and carry SHALL be discarded.
REQ-016 For a legal instruction, at the rising clk edge, result SHALL load the ALU output and register rd SHALL load the same value, unless rd is 0.
REQ-017 Latency SHALL be one edge; an instruction SHALL see all writes from earlier edges, so back-to-back dependent instructions need no stall.
REQ-018 For an illegal instruction (any other major opcode, or a funct7 not listed for the given funct3), result SHALL hold its value and no register SHALL be written.
REQ-019 For an rd=0 legal instruction, result SHALL still update; only the register write SHALL be suppressed.

Reset
REQ-020 While rst is high, result and all registers SHALL be 0 immediately, regardless of clk.
REQ-021 An instruction present at the edge when rst is released SHALL execute only if rst is low at that edge; a reset asserted mid-sequence SHALL discard all prior register state.

Verification
REQ-022 Assert rst, then apply 32'b0000000_00000_00001_00000_000_0110011 (add x0,x1,x0) for two edges -> result=0, x0 stays 0.
REQ-023 Apply addi x1,x0,5, then addi x2,x0,-3, then add x3,x1,x2 -> result=5, then 0xFFFFFFFD, then 2 (N=32).
REQ-024 With x1=5 and x2=-3, apply sub x4,x1,x2; slt x5,x2,x1; sltu x6,x2,x1 -> result=8, then 1, then 0.
REQ-025 Apply srai x7,x2,1; srli x8,x2,28; slli x9,x1,31 -> result=0xFFFFFFFE, then 0xF, then 0x80000000.
REQ-026 Apply an illegal opcode (major opcode 1111111) after result=2 -> result stays 2 and the registers are unchanged.
REQ-027 Pulse rst between clk edges after the writes above, then apply add x10,x1,x3 -> result=0 immediately on reset and 0 after the next edge.
